mem_arbiter_l1: RTL and testbench

Arbitrates the single memory-side line port between the L1 instruction cache and the L1 data cache. Each cache presents a level request carrying a 32-bit address. The data cache may also carry a 256-bit write-back line. The arbiter grants one requester at a time with round-robin fairness, drives the memory port, and routes the returned line and a one-cycle valid pulse back to the winner. It sits between both L1 caches and the memory/L2 interface and also watches for memory timeouts.

---
 rtl/mem_arb_pkg.sv | 19 +
 rtl/arb_timeout_cnt.sv | 31 +++
 rtl/mem_arbiter_l1.sv | 116 +++++++++++
 tb/tb_mem_arbiter_l1.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the L1 instruction/data memory-port arbiter.
package mem_arb_pkg;

    localparam int ADDR_W   = 32;
    localparam int LINE_W   = 256;
    localparam int OFFSET_W = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef enum logic {
        GNT_I = 1'b0,
        GNT_D = 1'b1
    } gnt_t;

endpackage

// File: rtl/arb_timeout_cnt.sv
// Saturating wait-cycle counter with a sticky flag raised once the count reaches TIMEOUT.
module arb_timeout_cnt #(
    parameter int TIMEOUT = 1023,
    parameter int TO_W    = 10
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic            clear,
    input  logic            enable,
    output logic [TO_W-1:0] count,
    output logic            timeout
);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            count   <= '0;
            timeout <= 1'b0;
        end else begin
            if (clear) begin
                count <= '0;
            end else if (enable && (count != '1)) begin
                count <= count + 1'b1;
            end
            // Flag lands in the same cycle the count becomes TIMEOUT; never cleared by 'clear'.
            if (!clear && enable && (count >= TO_W'(TIMEOUT - 1))) begin
                timeout <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter_l1.sv
// Round-robin arbiter sharing one memory line port between the L1 I-cache and D-cache.
module mem_arbiter_l1
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W   = mem_arb_pkg::ADDR_W,
    parameter int LINE_W   = mem_arb_pkg::LINE_W,
    parameter int OFFSET_W = mem_arb_pkg::OFFSET_W,
    parameter int TIMEOUT  = 1023,
    parameter int TO_W     = 10
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [LINE_W-1:0] i_data,
    output logic              i_valid,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_valid,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_address,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_data,
    input  logic              mem_valid,
    output logic              busy,
    output logic              timeout_err
);

    state_t          state;
    gnt_t            last_grant;
    gnt_t            winner;
    gnt_t            grant_sel;
    logic            grant_any;
    logic [TO_W-1:0] to_count_unused;

    function automatic logic [ADDR_W-1:0] line_align(input logic [ADDR_W-1:0] addr);
        return {addr[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
    endfunction

    // The I-cache wins a tie only when the D-cache was served last.
    assign grant_any = i_req | d_req;
    assign grant_sel = (i_req && (!d_req || (last_grant == GNT_D))) ? GNT_I : GNT_D;
    assign busy      = (state != IDLE);

    arb_timeout_cnt #(
        .TIMEOUT (TIMEOUT),
        .TO_W    (TO_W)
    ) u_timeout (
        .CLK     (CLK),
        .RESET   (RESET),
        .clear   ((state == IDLE) && grant_any),
        .enable  ((state == WAIT) && !mem_valid),
        .count   (to_count_unused),
        .timeout (timeout_err)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state       <= IDLE;
            last_grant  <= GNT_D;
            winner      <= GNT_I;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_address <= '0;
            mem_wdata   <= '0;
            i_data      <= '0;
            i_valid     <= 1'b0;
            d_rdata     <= '0;
            d_valid     <= 1'b0;
        end else begin
            i_valid <= 1'b0;
            d_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        winner  <= grant_sel;
                        mem_req <= 1'b1;
                        state   <= WAIT;
                        if (grant_sel == GNT_D) begin
                            mem_we      <= d_we;
                            mem_address <= line_align(d_addr);
                            mem_wdata   <= d_wdata;
                        end else begin
                            mem_we      <= 1'b0;
                            mem_address <= line_align(i_addr);
                            mem_wdata   <= '0;
                        end
                    end
                end
                WAIT: begin
                    if (mem_valid) begin
                        if (winner == GNT_I) begin
                            i_data  <= mem_data;
                            i_valid <= 1'b1;
                        end else begin
                            if (!mem_we) begin
                                d_rdata <= mem_data;
                            end
                            d_valid <= 1'b1;
                        end
                        mem_req    <= 1'b0;
                        last_grant <= winner;
                        state      <= RESP;
                    end
                end
                RESP: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter_l1.sv
// Directed bench for mem_arbiter_l1: reads, write-back, contention, timeout, reset and spurious completions.
module tb_mem_arbiter_l1;

    localparam int ADDR_W = 32;
    localparam int LINE_W = 256;

    logic              CLK = 1'b0;
    logic              RESET;
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic [LINE_W-1:0] i_data;
    logic              i_valid;
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [LINE_W-1:0] d_wdata;
    logic [LINE_W-1:0] d_rdata;
    logic              d_valid;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_address;
    logic [LINE_W-1:0] mem_wdata;
    logic [LINE_W-1:0] mem_data;
    logic              mem_valid;
    logic              busy;
    logic              timeout_err;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    mem_arbiter_l1 #(
        .TIMEOUT (8),
        .TO_W    (4)
    ) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .i_req       (i_req),
        .i_addr      (i_addr),
        .i_data      (i_data),
        .i_valid     (i_valid),
        .d_req       (d_req),
        .d_we        (d_we),
        .d_addr      (d_addr),
        .d_wdata     (d_wdata),
        .d_rdata     (d_rdata),
        .d_valid     (d_valid),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_address (mem_address),
        .mem_wdata   (mem_wdata),
        .mem_data    (mem_data),
        .mem_valid   (mem_valid),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    logic [LINE_W-1:0] pat_a5;
    logic [LINE_W-1:0] pat_11;
    logic [LINE_W-1:0] pat_de;
    logic [LINE_W-1:0] pat_k;
    logic [LINE_W-1:0] last_i;
    logic [LINE_W-1:0] last_d;

    initial begin
        pat_a5 = {32{8'hA5}};
        pat_11 = {32{8'h11}};
        pat_de = {8{32'hDEAD_BEEF}};
        RESET = 1'b1; i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_we = 1'b0;
        d_addr = '0; d_wdata = '0; mem_data = '0; mem_valid = 1'b0;
        tick(); tick();
        chk("rst_mem_req", mem_req, 0);
        chk("rst_busy", busy, 0);
        chk("rst_timeout", timeout_err, 0);
        chk("rst_i_valid", i_valid, 0);
        chk("rst_d_valid", d_valid, 0);
        chk("rst_i_data", i_data, 0);
        RESET = 1'b0;
        tick();

        // 1: I-cache read
        i_req = 1'b1; i_addr = 32'h0000_1234;
        tick();
        chk("t1_mem_req", mem_req, 1);
        chk("t1_addr", mem_address, 32'h0000_1220);
        chk("t1_we", mem_we, 0);
        chk("t1_busy", busy, 1);
        tick(); tick(); tick();
        chk("t1_req_held", mem_req, 1);
        chk("t1_no_early_valid", i_valid, 0);
        mem_valid = 1'b1; mem_data = pat_a5;
        tick();
        chk("t1_i_valid", i_valid, 1);
        chk("t1_i_data", i_data, pat_a5);
        chk("t1_d_valid", d_valid, 0);
        chk("t1_req_drop", mem_req, 0);
        mem_valid = 1'b0; i_req = 1'b0;
        tick();
        chk("t1_i_valid_pulse", i_valid, 0);
        chk("t1_idle", busy, 0);

        // 2: D-cache write-back
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h8000_0040; d_wdata = pat_11;
        tick();
        chk("t2_we", mem_we, 1);
        chk("t2_addr", mem_address, 32'h8000_0040);
        chk("t2_wdata", mem_wdata, pat_11);
        tick(); tick();
        chk("t2_wdata_held", mem_wdata, pat_11);
        chk("t2_req_held", mem_req, 1);
        mem_valid = 1'b1; mem_data = pat_de;
        tick();
        chk("t2_d_valid", d_valid, 1);
        chk("t2_d_rdata_kept", d_rdata, 0);
        chk("t2_i_valid", i_valid, 0);
        chk("t2_i_data_kept", i_data, pat_a5);
        mem_valid = 1'b0; d_req = 1'b0; d_we = 1'b0; d_wdata = '0;
        tick();
        chk("t2_d_valid_pulse", d_valid, 0);

        // 3: contention, expected order I, D, I, D
        i_req = 1'b1; i_addr = 32'h0000_0105;
        d_req = 1'b1; d_addr = 32'h0000_0207;
        last_i = pat_a5;
        last_d = '0;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("t3_mem_req", mem_req, 1);
            chk("t3_addr", mem_address, (k % 2 == 0) ? 32'h0000_0100 : 32'h0000_0200);
            chk("t3_we", mem_we, 0);
            tick();
            pat_k = {8{32'hC0DE_0000 + 32'(k)}};
            mem_valid = 1'b1; mem_data = pat_k;
            tick();
            if (k % 2 == 0) last_i = pat_k; else last_d = pat_k;
            chk("t3_i_valid", i_valid, (k % 2 == 0) ? 1 : 0);
            chk("t3_d_valid", d_valid, (k % 2 == 0) ? 0 : 1);
            chk("t3_i_data", i_data, last_i);
            chk("t3_d_rdata", d_rdata, last_d);
            mem_valid = 1'b0;
            tick();
            chk("t3_gap_req", mem_req, 0);
        end
        i_req = 1'b0; d_req = 1'b0;
        tick();
        chk("t3_idle", busy, 0);

        // 4: timeout with TIMEOUT=8
        i_req = 1'b1; i_addr = 32'h0000_4000;
        tick();
        chk("t4_mem_req", mem_req, 1);
        repeat (7) tick();
        chk("t4_no_timeout_yet", timeout_err, 0);
        tick();
        chk("t4_timeout", timeout_err, 1);
        chk("t4_still_waiting", mem_req, 1);
        repeat (12) tick();
        chk("t4_sticky", timeout_err, 1);
        chk("t4_req_held", mem_req, 1);
        mem_valid = 1'b1; mem_data = pat_11;
        tick();
        chk("t4_i_valid", i_valid, 1);
        chk("t4_i_data", i_data, pat_11);
        chk("t4_sticky_after", timeout_err, 1);
        mem_valid = 1'b0; i_req = 1'b0;
        tick();

        // 5: reset during WAIT
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0040;
        tick();
        chk("t5_mem_req", mem_req, 1);
        tick();
        RESET = 1'b1;
        tick();
        chk("t5_req_cleared", mem_req, 0);
        chk("t5_busy", busy, 0);
        chk("t5_timeout_cleared", timeout_err, 0);
        RESET = 1'b0; d_req = 1'b0;
        mem_valid = 1'b1; mem_data = pat_de;
        tick();
        chk("t5_no_i_valid", i_valid, 0);
        chk("t5_no_d_valid", d_valid, 0);
        chk("t5_d_rdata", d_rdata, 0);
        mem_valid = 1'b0;
        tick();

        // 6: spurious mem_valid in IDLE
        mem_valid = 1'b1; mem_data = pat_a5;
        tick();
        chk("t6_i_valid", i_valid, 0);
        chk("t6_d_valid", d_valid, 0);
        chk("t6_busy", busy, 0);
        chk("t6_mem_req", mem_req, 0);
        chk("t6_i_data", i_data, 0);
        chk("t6_timeout", timeout_err, 0);
        mem_valid = 1'b0;
        tick();
        chk("t6_still_idle", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
